// File: rtl/core_pkg.sv
// Shared core types for the fetch stage: data width, IF/ID payload, NOP encoding
// and the fetch FSM state type.
package core_pkg;

  localparam int DataSize = 32;

  typedef logic [31:0] instruction_t;

  typedef struct packed {
    logic [DataSize-1:0] pc;
    instruction_t        inst;
  } if_id_t;

  // addi x0, x0, 0
  localparam instruction_t NOP = 32'h0000_0013;

  localparam logic [DataSize-1:0] InstBytes = DataSize'(4);

  localparam if_id_t IfIdNop = '{pc: '0, inst: NOP};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage with an inline skid register and IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned fetch addresses into a fault.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [DataSize-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                inst_mem_rd_en,
  output logic [DataSize-1:0] inst_mem_addr,
  input  logic                inst_mem_ack,
  input  logic [31:0]         inst_mem_rd_dat,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect_en,
  input  logic [DataSize-1:0] redirect_pc,
  output if_id_t              if_id,
  output logic                if_id_valid,
  output logic                misaligned_fault
);

  fetch_state_t        state_q, state_d;
  logic [DataSize-1:0] pc_q, pc_d;
  logic [DataSize-1:0] drain_addr_q, drain_addr_d;
  if_id_t              skid_q, skid_d;
  if_id_t              if_id_q, if_id_d;
  logic                if_id_valid_q, if_id_valid_d;

  logic                req_active;
  logic                ack_seen;
  logic                pc_misaligned;
  logic                fault_pending;
  logic                trap_fire;
  logic [DataSize-1:0] redirect_tgt;
  if_id_t              fresh;
  logic                fresh_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign redirect_tgt  = redirect_pc;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign fault_pending = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_en || flush) begin
      fault_d = 1'b0;
    end else if (trap_fire) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign misaligned_fault = fault_q;
`else
  // Targets are word aligned by construction, so the fault can never occur.
  assign redirect_tgt     = redirect_pc & ~{{(DataSize-2){1'b0}}, 2'b11};
  assign pc_misaligned    = 1'b0;
  assign fault_pending    = 1'b0;
  assign misaligned_fault = 1'b0;
`endif

  // A request is live in FETCH (unless the pc is faulting) and in DRAIN.
  assign req_active = !reset &&
                      (((state_q == FETCH) && !pc_misaligned) || (state_q == DRAIN));
  assign ack_seen   = req_active && inst_mem_ack;
  assign trap_fire  = (state_q == FETCH) && pc_misaligned && !fault_pending &&
                      !stall && !flush && !redirect_en;

  assign inst_mem_rd_en = req_active;
  assign inst_mem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    skid_d        = skid_q;
    if_id_d       = if_id_q;
    if_id_valid_d = if_id_valid_q;
    fresh         = skid_q;
    fresh_valid   = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
          // The pending request must complete at its old address before refetching.
          if (req_active && !inst_mem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (ack_seen) begin
          pc_d = pc_q + InstBytes;
          if (!flush && stall) begin
            skid_d  = '{pc: pc_q, inst: inst_mem_rd_dat};
            state_d = HOLD;
          end else if (!flush) begin
            fresh       = '{pc: pc_q, inst: inst_mem_rd_dat};
            fresh_valid = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirect_en) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (flush) begin
          state_d = FETCH;
        end else if (!stall) begin
          fresh_valid = 1'b1;
          state_d     = FETCH;
        end
      end

      DRAIN: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
        end
        if (ack_seen) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (flush) begin
      if_id_d       = IfIdNop;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      if_id_d       = if_id_q;
      if_id_valid_d = if_id_valid_q;
    end else if (fresh_valid) begin
      if_id_d       = fresh;
      if_id_valid_d = 1'b1;
    end else if (trap_fire) begin
      if_id_d       = '{pc: pc_q, inst: NOP};
      if_id_valid_d = 1'b1;
    end else begin
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      drain_addr_q  <= '0;
      skid_q        <= '0;
      if_id_q       <= IfIdNop;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      skid_q        <= skid_d;
      if_id_q       <= if_id_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id       = if_id_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected IF/ID contents are queued as each
// cycle is driven and compared once the clock edge has produced them.
module tb_instruction_fetch;
  import core_pkg::*;

  localparam logic [31:0] NOPI  = 32'h0000_0013;
  localparam bit [1:0]    FULL  = 2'b11;
  localparam bit [1:0]    VONLY = 2'b00;
  localparam bit [1:0]    PCV   = 2'b10;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    bit   [1:0]  cmask;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        inst_mem_rd_en;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_ack;
  logic [31:0] inst_mem_rd_dat;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  if_id_t      if_id;
  logic        if_id_valid;
  logic        misaligned_fault;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic [31:0] tail_pc;

  instruction_fetch #(.RESET_PC(32'h0000_1000)) dut (
    .clock           (clock),
    .reset           (reset),
    .inst_mem_rd_en  (inst_mem_rd_en),
    .inst_mem_addr   (inst_mem_addr),
    .inst_mem_ack    (inst_mem_ack),
    .inst_mem_rd_dat (inst_mem_rd_dat),
    .stall           (stall),
    .flush           (flush),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .if_id           (if_id),
    .if_id_valid     (if_id_valid),
    .misaligned_fault(misaligned_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the live request, drive memory/control, queue the
  // IF/ID value expected after the edge, then retire due expectations.
  task automatic step(input string tag, input logic exp_en, input logic [31:0] exp_addr,
                      input logic ack, input logic stl, input logic fl,
                      input logic rd, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                      input bit [1:0] cmask);
    exp_t e;
    chk({tag, "/rd_en"}, 64'(inst_mem_rd_en), 64'(exp_en));
    if (exp_en) chk({tag, "/addr"}, 64'(inst_mem_addr), 64'(exp_addr));
    inst_mem_ack    = ack;
    inst_mem_rd_dat = ack ? memf(exp_addr) : 32'hBAD0_BAD0;
    stall           = stl;
    flush           = fl;
    redirect_en     = rd;
    redirect_pc     = rpc;
    sb.push_back('{tag: tag, pc: epc, inst: einst, valid: ev, cmask: cmask, due: cyc + 1});
    @(posedge clock);
    #1;
    cyc++;
    inst_mem_ack = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = 32'h0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "/valid"}, 64'(if_id_valid), 64'(e.valid));
      if (e.cmask[1]) chk({e.tag, "/pc"}, 64'(if_id.pc), 64'(e.pc));
      if (e.cmask[0]) chk({e.tag, "/inst"}, 64'(if_id.inst), 64'(e.inst));
      $display("[cyc %0d] %s: if_id pc=%h inst=%h valid=%0b", cyc, e.tag,
               if_id.pc, if_id.inst, if_id_valid);
    end
  endtask

  initial begin
    reset           = 1'b1;
    inst_mem_ack    = 1'b0;
    inst_mem_rd_dat = 32'h0;
    stall           = 1'b0;
    flush           = 1'b0;
    redirect_en     = 1'b0;
    redirect_pc     = 32'h0;

    @(posedge clock); #1;
    chk("rst/rd_en", 64'(inst_mem_rd_en), 64'(0));
    @(posedge clock); #1;
    chk("rst/if_id", {if_id.pc, if_id.inst}, {32'h0, NOPI});
    chk("rst/valid", 64'(if_id_valid), 64'(0));
    chk("rst/fault", 64'(misaligned_fault), 64'(0));
    reset = 1'b0;
    #1;

    // zero-wait streaming from RESET_PC
    step("seq0", 1, 32'h1000, 1, 0, 0, 0, 0, 1, 32'h1000, memf(32'h1000), FULL);
    step("seq1", 1, 32'h1004, 1, 0, 0, 0, 0, 1, 32'h1004, memf(32'h1004), FULL);
    step("seq2", 1, 32'h1008, 1, 0, 0, 0, 0, 1, 32'h1008, memf(32'h1008), FULL);

    // stalled ack goes to the skid register, IF/ID holds
    step("stall_ack", 1, 32'h100C, 1, 1, 0, 0, 0, 1, 32'h1008, memf(32'h1008), FULL);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 0, 32'h0, 0, 1, 0, 0, 0, 1, 32'h1008, memf(32'h1008), FULL);
    step("skid_out", 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h100C, memf(32'h100C), FULL);
    step("post_skid", 1, 32'h1010, 1, 0, 0, 0, 0, 1, 32'h1010, memf(32'h1010), FULL);
    step("bubble", 1, 32'h1014, 0, 0, 0, 0, 0, 0, 0, 0, VONLY);

    // redirect during a wait: old address held, data dropped
    step("redir_wait", 1, 32'h1014, 0, 0, 0, 1, 32'h2000, 0, 0, 0, VONLY);
    step("drain_wait", 1, 32'h1014, 0, 0, 0, 0, 0, 0, 0, 0, VONLY);
    step("drain_ack", 1, 32'h1014, 1, 0, 0, 0, 0, 0, 0, 0, VONLY);
    step("after_drain", 1, 32'h2000, 1, 0, 0, 0, 0, 1, 32'h2000, memf(32'h2000), FULL);
    step("redir_wait2", 1, 32'h2004, 0, 0, 0, 1, 32'h3000, 0, 0, 0, VONLY);
    step("drain_redir", 1, 32'h2004, 0, 0, 0, 1, 32'h3100, 0, 0, 0, VONLY);
    step("drain_ack2", 1, 32'h2004, 1, 0, 0, 0, 0, 0, 0, 0, VONLY);

    // flush beats stall and ack; redirect with ack / with stall / in HOLD
    step("flush_stall", 1, 32'h3100, 1, 1, 1, 0, 0, 0, 32'h0, NOPI, FULL);
    step("post_flush", 1, 32'h3104, 1, 0, 0, 0, 0, 1, 32'h3104, memf(32'h3104), FULL);
    step("redir_ack", 1, 32'h3108, 1, 0, 0, 1, 32'h4000, 0, 0, 0, VONLY);
    step("redir_stall", 1, 32'h4000, 1, 1, 0, 1, 32'h5000, 0, 0, 0, VONLY);
    step("after_rs", 1, 32'h5000, 1, 0, 0, 0, 0, 1, 32'h5000, memf(32'h5000), FULL);
    step("stall_ack2", 1, 32'h5004, 1, 1, 0, 0, 0, 1, 32'h5000, memf(32'h5000), FULL);
    step("redir_hold", 0, 32'h0, 0, 0, 0, 1, 32'h6000, 0, 0, 0, VONLY);
    step("after_rh", 1, 32'h6000, 1, 0, 0, 0, 0, 1, 32'h6000, memf(32'h6000), FULL);

    // pc wraps at the top of the address space
    step("redir_top", 1, 32'h6004, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, VONLY);
    step("drain_top", 1, 32'h6004, 1, 0, 0, 0, 0, 0, 0, 0, VONLY);
    step("top_pc", 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, memf(32'hFFFF_FFFC), FULL);
    step("wrap", 1, 32'h0000_0000, 1, 0, 0, 0, 0, 1, 32'h0, memf(32'h0), FULL);

`ifdef FETCH_MISALIGN_TRAP_EN
    step("redir_odd", 1, 32'h4, 1, 0, 0, 1, 32'h2002, 0, 0, 0, VONLY);
    chk("redir_odd/fault", 64'(misaligned_fault), 64'(0));
    step("trap", 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h2002, NOPI, FULL);
    chk("trap/fault", 64'(misaligned_fault), 64'(1));
    step("trap_hold", 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h2002, 0, PCV);
    chk("trap_hold/fault", 64'(misaligned_fault), 64'(1));
    step("trap_clear", 0, 32'h0, 0, 0, 0, 1, 32'h3000, 0, 32'h2002, 0, PCV);
    chk("trap_clear/fault", 64'(misaligned_fault), 64'(0));
    step("aligned", 1, 32'h3000, 1, 0, 0, 0, 0, 1, 32'h3000, memf(32'h3000), FULL);
    tail_pc = 32'h3004;
`else
    step("redir_odd", 1, 32'h4, 1, 0, 0, 1, 32'h2002, 0, 0, 0, VONLY);
    chk("redir_odd/fault", 64'(misaligned_fault), 64'(0));
    step("aligned", 1, 32'h2000, 1, 0, 0, 0, 0, 1, 32'h2000, memf(32'h2000), FULL);
    chk("aligned/fault", 64'(misaligned_fault), 64'(0));
    tail_pc = 32'h2004;
`endif

    // reset abandons an outstanding request
    step("pre_reset", 1, tail_pc, 0, 0, 0, 0, 0, 0, 0, 0, VONLY);
    reset = 1'b1;
    #1;
    chk("in_reset/rd_en", 64'(inst_mem_rd_en), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_reset/if_id", {if_id.pc, if_id.inst}, {32'h0, NOPI});
    chk("post_reset/valid", 64'(if_id_valid), 64'(0));
    step("restart", 1, 32'h1000, 1, 0, 0, 0, 0, 1, 32'h1000, memf(32'h1000), FULL);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
